// File: rtl/spi_bus_arbiter_if.sv
// Bundle of signals between the SPI bus arbiter, its client blocks and the
// byte-level SPI master.
//
// Handshake rules:
//   req_*  : a byte moves from requester i when req_valid[i] && req_ready[i]
//            are both high in the same cycle. req_ready never depends on
//            anything other than the arbiter state and spi_axiready.
//   resp_* : resp_valid[i] is a one-cycle pulse with no backpressure. The
//            owner must take resp_data/resp_last in that cycle.
//   spi_*  : spi_axiiv is high for exactly one cycle per byte and only while
//            spi_axiready is high. spi_axiov is a one-cycle done pulse
//            carrying the MISO byte on spi_axiod.
interface spi_bus_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // client side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          resp_last;
    logic                          burst_abort;
    logic [GW-1:0]                 grant;
    logic                          busy;

    // SPI master side
    logic                          spi_axiiv;
    logic [DATA_WIDTH-1:0]         spi_axiid;
    logic                          spi_axiready;
    logic                          spi_axiov;
    logic [DATA_WIDTH-1:0]         spi_axiod;

    // arbiter view
    modport slave (
        input  req_valid, req_data, req_last,
        input  spi_axiready, spi_axiov, spi_axiod,
        output req_ready, resp_valid, resp_data, resp_last,
        output burst_abort, grant, busy,
        output spi_axiiv, spi_axiid
    );

    // client / SPI master view
    modport master (
        output req_valid, req_data, req_last,
        output spi_axiready, spi_axiov, spi_axiod,
        input  req_ready, resp_valid, resp_data, resp_last,
        input  burst_abort, grant, busy,
        input  spi_axiiv, spi_axiid
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level SPI master between NUM_REQ
// clients. A grant lasts for a whole burst (ended by req_last); every MOSI
// byte produces exactly one MISO byte routed back to the burst owner. An
// owner that stops offering bytes mid-burst for STALL_LIMIT cycles loses
// the grant (burst_abort). STALL_LIMIT must be at least 2.
module spi_bus_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int STALL_LIMIT = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_bus_arbiter_if.slave     bus,
    output logic [1:0]           dbg_state
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t                 state;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          grant_q;
    logic                   last_q;
    logic [SW-1:0]          stall_cnt;
    logic [NUM_REQ-1:0]     resp_valid_q;
    logic [DATA_WIDTH-1:0]  resp_data_q;
    logic                   resp_last_q;
    logic                   abort_q;

    // combinational helpers
    logic [GW-1:0]          pick_idx;
    logic                   pick_found;
    logic [GW:0]            cand_wide;
    logic [GW-1:0]          cand;
    logic                   owner_valid;
    logic                   owner_last;
    logic [DATA_WIDTH-1:0]  owner_data;
    logic [NUM_REQ-1:0]     ready_vec;
    logic                   xfer;

    // Next pointer after a burst ends, wrapping at NUM_REQ-1 so that indices
    // beyond the last requester are never reached.
    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
        if (g == GW'(NUM_REQ - 1)) begin
            return '0;
        end
        return g + GW'(1);
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr;
        cand_wide  = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_wide = {1'b0, rr_ptr} + (GW+1)'(i);
            if (cand_wide >= (GW+1)'(NUM_REQ)) begin
                cand_wide = cand_wide - (GW+1)'(NUM_REQ);
            end
            cand = cand_wide[GW-1:0];
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the owner's request lines.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_last  = bus.req_last[i];
                owner_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the owner sees ready, and only while the master can start a byte.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state == ISSUE && bus.spi_axiready && grant_q == GW'(i)) begin
                ready_vec[i] = 1'b1;
            end
        end
    end

    // A byte leaves for the SPI master in the same cycle it is accepted.
    assign xfer          = (state == ISSUE) && bus.spi_axiready && owner_valid;
    assign bus.req_ready = ready_vec;
    assign bus.spi_axiiv = xfer;
    assign bus.spi_axiid = xfer ? owner_data : '0;

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_last   = resp_last_q;
    assign bus.burst_abort = abort_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state != IDLE);
    assign dbg_state       = state;

    // Burst FSM: arbitrate, issue one byte, wait for its MISO byte, repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            last_q       <= 1'b0;
            stall_cnt    <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            resp_valid_q <= '0;
            abort_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found && bus.spi_axiready) begin
                        grant_q   <= pick_idx;
                        stall_cnt <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        last_q    <= owner_last;
                        stall_cnt <= '0;
                        state     <= WAIT_RESP;
                    end else if (!owner_valid) begin
                        // Only an absent owner counts; a busy master does not.
                        if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                            abort_q   <= 1'b1;
                            rr_ptr    <= wrap_inc(grant_q);
                            stall_cnt <= '0;
                            state     <= IDLE;
                        end else begin
                            stall_cnt <= stall_cnt + SW'(1);
                        end
                    end
                end
                WAIT_RESP: begin
                    if (bus.spi_axiov) begin
                        resp_valid_q[grant_q] <= 1'b1;
                        resp_data_q           <= bus.spi_axiod;
                        resp_last_q           <= last_q;
                        if (last_q) begin
                            rr_ptr <= wrap_inc(grant_q);
                            state  <= IDLE;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
